lockstep_trace_aligner: RTL and testbench

//   Upstream feeder for the lockstep comparator. Two retire-trace streams (DUT core, reference

---
 rtl/lockstep_trace_aligner_if.sv | 35 +++
 rtl/lockstep_trace_aligner.sv | 123 ++++++++++++
 tb/tb_lockstep_trace_aligner.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/lockstep_trace_aligner_if.sv
// Trace-alignment bus: two pushed trace streams in, one aligned pair plus status out.
interface lockstep_trace_aligner_if #(
  parameter int unsigned LENGTH = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic              flush;
  logic [LENGTH-1:0] in1_data;
  logic              in1_valid;
  logic [LENGTH-1:0] in2_data;
  logic              in2_valid;
  logic [LENGTH-1:0] out1_data;
  logic              out1_enable;
  logic [LENGTH-1:0] out2_data;
  logic              out2_enable;
  logic [CW-1:0]     count1;
  logic [CW-1:0]     count2;
  logic              overflow1;
  logic              overflow2;
  logic [CNT_W-1:0]  pairs_emitted;

  modport master (
    output flush, in1_data, in1_valid, in2_data, in2_valid,
    input  out1_data, out1_enable, out2_data, out2_enable,
    input  count1, count2, overflow1, overflow2, pairs_emitted
  );

  modport slave (
    input  flush, in1_data, in1_valid, in2_data, in2_valid,
    output out1_data, out1_enable, out2_data, out2_enable,
    output count1, count2, overflow1, overflow2, pairs_emitted
  );
endinterface

// File: rtl/lockstep_trace_aligner.sv
// Buffers two skewed retire-trace streams in per-stream FIFOs and emits them as
// single-cycle aligned pairs for the lockstep comparator.
module lockstep_trace_aligner #(
  parameter int unsigned LENGTH = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  lockstep_trace_aligner_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [LENGTH-1:0] mem1_q [DEPTH];
  logic [LENGTH-1:0] mem2_q [DEPTH];

  logic [PW-1:0]     rd1_q, rd1_d, wr1_q, wr1_d;
  logic [PW-1:0]     rd2_q, rd2_d, wr2_q, wr2_d;
  logic [CW-1:0]     count1_q, count1_d, count2_q, count2_d;
  logic              ov1_q, ov1_d, ov2_q, ov2_d;
  logic [LENGTH-1:0] out1_q, out1_d, out2_q, out2_d;
  logic              en_q, en_d;
  logic [CNT_W-1:0]  pairs_q, pairs_d;

  logic pop, push1, push2;

  // A full FIFO may still accept a push on an edge where it also pops.
  assign pop   = (count1_q != '0) && (count2_q != '0);
  assign push1 = bus.in1_valid && ((count1_q != CW'(DEPTH)) || pop);
  assign push2 = bus.in2_valid && ((count2_q != CW'(DEPTH)) || pop);

  // Next-state for pointers, occupancy, status and the registered pair outputs.
  always_comb begin
    rd1_d    = rd1_q;
    wr1_d    = wr1_q;
    rd2_d    = rd2_q;
    wr2_d    = wr2_q;
    count1_d = count1_q;
    count2_d = count2_q;
    ov1_d    = ov1_q;
    ov2_d    = ov2_q;
    out1_d   = out1_q;
    out2_d   = out2_q;
    en_d     = 1'b0;
    pairs_d  = pairs_q;
    if (bus.flush) begin
      rd1_d    = '0;
      wr1_d    = '0;
      rd2_d    = '0;
      wr2_d    = '0;
      count1_d = '0;
      count2_d = '0;
      ov1_d    = 1'b0;
      ov2_d    = 1'b0;
      out1_d   = '0;
      out2_d   = '0;
      pairs_d  = '0;
    end else begin
      if (pop) begin
        out1_d = mem1_q[rd1_q];
        out2_d = mem2_q[rd2_q];
        en_d   = 1'b1;
        rd1_d  = rd1_q + PW'(1);
        rd2_d  = rd2_q + PW'(1);
        if (pairs_q != '1) pairs_d = pairs_q + CNT_W'(1);
      end
      if (push1) wr1_d = wr1_q + PW'(1);
      if (push2) wr2_d = wr2_q + PW'(1);
      if (bus.in1_valid && !push1) ov1_d = 1'b1;
      if (bus.in2_valid && !push2) ov2_d = 1'b1;
      count1_d = count1_q + CW'(push1) - CW'(pop);
      count2_d = count2_q + CW'(push2) - CW'(pop);
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (!bus.flush && push1) mem1_q[wr1_q] <= bus.in1_data;
    if (!bus.flush && push2) mem2_q[wr2_q] <= bus.in2_data;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_q    <= '0;
      wr1_q    <= '0;
      rd2_q    <= '0;
      wr2_q    <= '0;
      count1_q <= '0;
      count2_q <= '0;
      ov1_q    <= 1'b0;
      ov2_q    <= 1'b0;
      out1_q   <= '0;
      out2_q   <= '0;
      en_q     <= 1'b0;
      pairs_q  <= '0;
    end else begin
      rd1_q    <= rd1_d;
      wr1_q    <= wr1_d;
      rd2_q    <= rd2_d;
      wr2_q    <= wr2_d;
      count1_q <= count1_d;
      count2_q <= count2_d;
      ov1_q    <= ov1_d;
      ov2_q    <= ov2_d;
      out1_q   <= out1_d;
      out2_q   <= out2_d;
      en_q     <= en_d;
      pairs_q  <= pairs_d;
    end
  end

  assign bus.out1_data     = out1_q;
  assign bus.out2_data     = out2_q;
  assign bus.out1_enable   = en_q;
  assign bus.out2_enable   = en_q;
  assign bus.count1        = count1_q;
  assign bus.count2        = count2_q;
  assign bus.overflow1     = ov1_q;
  assign bus.overflow2     = ov2_q;
  assign bus.pairs_emitted = pairs_q;
endmodule

// File: tb/tb_lockstep_trace_aligner.sv
// Randomized and directed checks of the trace aligner against a queue-based model.
module tb_lockstep_trace_aligner;
  localparam int unsigned LENGTH = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lockstep_trace_aligner_if #(.LENGTH(LENGTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  lockstep_trace_aligner #(.LENGTH(LENGTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: two queues plus the visible output/status state.
  logic [7:0]  q1[$];
  logic [7:0]  q2[$];
  logic [7:0]  m_d1, m_d2;
  bit          m_en, m_ov1, m_ov2;
  int unsigned m_pairs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    q1.delete();
    q2.delete();
    m_d1 = '0;
    m_d2 = '0;
    m_en = 1'b0;
    m_ov1 = 1'b0;
    m_ov2 = 1'b0;
    m_pairs = 0;
  endfunction

  // One clock edge of the aligner, in terms of queues.
  function automatic void model_step();
    bit pop;
    if (bus.flush) begin
      model_reset();
    end else begin
      pop = (q1.size() > 0) && (q2.size() > 0);
      m_en = pop;
      if (pop) begin
        m_d1 = q1.pop_front();
        m_d2 = q2.pop_front();
        if (m_pairs < (1 << CNT_W) - 1) m_pairs++;
      end
      if (bus.in1_valid) begin
        if (q1.size() < DEPTH) q1.push_back(bus.in1_data);
        else m_ov1 = 1'b1;
      end
      if (bus.in2_valid) begin
        if (q2.size() < DEPTH) q2.push_back(bus.in2_data);
        else m_ov2 = 1'b1;
      end
    end
  endfunction

  task automatic check_all();
    chk("count1", 32'(bus.count1), 32'(q1.size()));
    chk("count2", 32'(bus.count2), 32'(q2.size()));
    chk("out1_enable", 32'(bus.out1_enable), 32'(m_en));
    chk("out2_enable", 32'(bus.out2_enable), 32'(m_en));
    chk("out1_data", 32'(bus.out1_data), 32'(m_d1));
    chk("out2_data", 32'(bus.out2_data), 32'(m_d2));
    chk("overflow1", 32'(bus.overflow1), 32'(m_ov1));
    chk("overflow2", 32'(bus.overflow2), 32'(m_ov2));
    chk("pairs_emitted", 32'(bus.pairs_emitted), m_pairs);
  endtask

  task automatic drive(input bit v1, input logic [7:0] d1, input bit v2, input logic [7:0] d2,
                       input bit fl);
    bus.in1_valid = v1;
    bus.in1_data  = v1 ? d1 : 8'($urandom);
    bus.in2_valid = v2;
    bus.in2_data  = v2 ? d2 : 8'($urandom);
    bus.flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      step();
    end
  endtask

  initial begin
    model_reset();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    #11;
    check_all();
    rst_n = 1'b1;
    idle(1);

    // Simultaneous push: pair appears one cycle after the push edge.
    drive(1'b1, 8'h11, 1'b1, 8'h11, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    step();
    chk("t1_out1", 32'(bus.out1_data), 32'h11);
    chk("t1_out2", 32'(bus.out2_data), 32'h11);
    chk("t1_en", 32'(bus.out1_enable), 32'd1);
    chk("t1_pairs", 32'(bus.pairs_emitted), 32'd1);
    idle(1);
    chk("t1_en_drop", 32'(bus.out1_enable), 32'd0);

    // Stream 1 leads by three entries.
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 8'(i), 1'b0, 8'h00, 1'b0);
      step();
    end
    chk("t2_count1_peak", 32'(bus.count1), 32'd3);
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 8'h00, 1'b1, 8'(i), 1'b0);
      step();
    end
    idle(3);

    // Overflow on stream 1, then drain in order.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(8'hA0 + i), 1'b0, 8'h00, 1'b0);
      step();
    end
    chk("t3_count1_full", 32'(bus.count1), 32'd4);
    chk("t3_overflow1", 32'(bus.overflow1), 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 1'b1, 8'(8'hB0 + i), 1'b0);
      step();
    end
    idle(1);
    chk("t3_last_pair", 32'(bus.out1_data), 32'hA3);

    // High occupancy with sustained pushes on both streams.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'hC0 + i), 1'b0, 8'h00, 1'b0);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(8'hD0 + i), 1'b1, 8'(8'hE0 + i), 1'b0);
      step();
    end
    chk("t4_count1_hold", 32'(bus.count1), 32'd4);
    chk("t4_strobe", 32'(bus.out1_enable), 32'd1);

    // Flush concurrent with a stream-2 push.
    idle(6);
    drive(1'b1, 8'h21, 1'b0, 8'h00, 1'b0);
    step();
    drive(1'b1, 8'h22, 1'b0, 8'h00, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b1, 8'h77, 1'b1);
    step();
    chk("t5_count1", 32'(bus.count1), 32'd0);
    chk("t5_count2", 32'(bus.count2), 32'd0);
    chk("t5_ov1", 32'(bus.overflow1), 32'd0);
    chk("t5_pairs", 32'(bus.pairs_emitted), 32'd0);
    idle(2);
    chk("t5_no_strobe", 32'(bus.out1_enable), 32'd0);

    // Asynchronous reset with counts 2/1.
    drive(1'b1, 8'h31, 1'b0, 8'h00, 1'b0);
    step();
    drive(1'b1, 8'h32, 1'b0, 8'h00, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b1, 8'h41, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_count1_async", 32'(bus.count1), 32'd0);
    chk("t6_pairs_async", 32'(bus.pairs_emitted), 32'd0);
    check_all();
    #3;
    rst_n = 1'b1;
    drive(1'b1, 8'h5A, 1'b1, 8'h5B, 1'b0);
    step();
    idle(1);
    chk("t6_out1", 32'(bus.out1_data), 32'h5A);
    chk("t6_out2", 32'(bus.out2_data), 32'h5B);
    chk("t6_pairs", 32'(bus.pairs_emitted), 32'd1);

    // Randomized traffic with shifting skew and occasional flushes.
    for (int i = 0; i < 600; i++) begin
      int unsigned p1, p2;
      p1 = ((i / 50) % 2 == 0) ? 80 : 30;
      p2 = ((i / 50) % 2 == 0) ? 30 : 80;
      drive($urandom_range(0, 99) < p1, 8'($urandom), $urandom_range(0, 99) < p2, 8'($urandom),
            $urandom_range(0, 59) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
